mem_bus_arbiter: RTL

//  Shares one SRAM-like memory bus between the fetch stage (read-only) and the Memory stage (load/store).

---
 rtl/mem_bus_arbiter_if.sv | 57 +++++
 rtl/mem_bus_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Bundles the fetch, load/store and memory-bus signals that
//               pass through the memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if;
    // fetch side
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    // load/store side
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    // memory bus side
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    // Arbiter view
    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    // Environment view: pipeline stages plus bus bridge
    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one SRAM-like bus between fetch and load/store with
//               grant locking, in-order response routing and anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int STARVE_MAX  = 4
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    mem_bus_arbiter_if.slave   arb
);

    localparam int   c_PTR_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int   c_CNT_W    = $clog2(OUTSTANDING + 1);
    localparam int   c_STV_W    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic c_OWN_INST = 1'b1;
    localparam logic c_OWN_DATA = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCK_INST = 2'd1,
        ST_LOCK_DATA = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_STV_W-1:0]   r_starve_cnt;
    logic                 r_owner [OUTSTANDING];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_grant_inst;
    logic                 w_full;
    logic                 w_bus_req;
    logic                 w_hs;
    logic                 w_pop;
    logic                 w_head;
    logic [3:0]           w_wstrb;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(OUTSTANDING - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Lock holds the presented request stable until the bus accepts it
    always_comb begin
        w_grant_inst = 1'b0;
        case (r_state)
            ST_LOCK_INST: w_grant_inst = 1'b1;
            ST_LOCK_DATA: w_grant_inst = 1'b0;
            default: begin
                if (arb.inst_req && (r_starve_cnt == c_STV_W'(STARVE_MAX)))
                    w_grant_inst = 1'b1;
                else
                    w_grant_inst = ~arb.data_req;
            end
        endcase
    end

    assign w_full    = (r_count == c_CNT_W'(OUTSTANDING));
    assign w_bus_req = (w_grant_inst ? arb.inst_req : arb.data_req) & ~w_full;
    assign w_hs      = w_bus_req & arb.bus_addr_ok;
    assign w_pop     = arb.bus_data_ok & (r_count != '0);
    assign w_head    = r_owner[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        if (w_hs)
            w_state_nxt = ST_IDLE;
        else if (w_bus_req)
            w_state_nxt = w_grant_inst ? ST_LOCK_INST : ST_LOCK_DATA;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_wstrb = 4'b0000;
        if (arb.bus_wr) begin
            case (arb.bus_size)
                2'd0:    w_wstrb = 4'b0001 << arb.bus_addr[1:0];
                2'd1:    w_wstrb = arb.bus_addr[1] ? 4'b1100 : 4'b0011;
                default: w_wstrb = 4'b1111;
            endcase
        end
    end

    assign arb.bus_req      = w_bus_req;
    assign arb.bus_wr       = w_grant_inst ? 1'b0       : arb.data_wr;
    assign arb.bus_size     = w_grant_inst ? 2'd2       : arb.data_size;
    assign arb.bus_addr     = w_grant_inst ? arb.inst_addr : arb.data_addr;
    assign arb.bus_wdata    = w_grant_inst ? 32'h0      : arb.data_wdata;
    assign arb.bus_wstrb    = w_wstrb;

    assign arb.inst_addr_ok = w_hs &  w_grant_inst;
    assign arb.data_addr_ok = w_hs & ~w_grant_inst;
    assign arb.inst_data_ok = w_pop & (w_head == c_OWN_INST);
    assign arb.data_data_ok = w_pop & (w_head == c_OWN_DATA);
    assign arb.inst_rdata   = arb.bus_rdata;
    assign arb.data_rdata   = arb.bus_rdata;

    // Owner storage needs no reset: r_count guards every read
    always_ff @(posedge clk) begin
        if (w_hs)
            r_owner[r_wr_ptr] <= w_grant_inst ? c_OWN_INST : c_OWN_DATA;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_hs)
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Counts data wins that happened while fetch was left waiting
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_starve_cnt <= '0;
        else if (!arb.inst_req)
            r_starve_cnt <= '0;
        else if (w_hs && w_grant_inst)
            r_starve_cnt <= '0;
        else if (w_hs && (r_starve_cnt != c_STV_W'(STARVE_MAX)))
            r_starve_cnt <= r_starve_cnt + c_STV_W'(1);
    end

endmodule

`default_nettype wire
